controlador_alineamiento: RTL and testbench
===========================================

CONTROLADOR_ALINEAMIENTO -- requirements
Module: controlador_alineamiento

Interface
REQ-001 Parameter COMAS_SYNC, default 3, SHALL set the number of consecutive boundary-aligned commas required to declare sync.
REQ-002 Parameter ERRORES_PERDIDA, default 4, SHALL set the number of consecutive erroneous words that causes loss of sync.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 entrada  input  1  SHALL carry the serial line bit, the same bit fed to serialParalelo.
REQ-006 habilitar  input  1  SHALL be the shift enable; when 0, all internal state and outputs hold.
REQ-007 rstContador  output  1  SHALL drive the serialParalelo counter reset (active-high).
REQ-008 palabra  output  10  SHALL carry the last word captured at an aligned boundary.
REQ-009 palabraValida  output  1  SHALL be a one-cycle strobe marking palabra as new.
REQ-010 sincronizado  output  1  SHALL be high only in state SINCRONIZADO.
REQ-011 comaDetectada  output  1  SHALL be a one-cycle strobe on any comma match, in any state.
REQ-012 estado  output  2  SHALL expose the state: 0=BUSCAR, 1=CONFIRMAR, 2=SINCRONIZADO; 3 unused.

Function
REQ-013 On each enabled edge, ventana SHALL shift as {ventana[8:0], entrada}; the earliest received bit ends in ventana[9].
REQ-014 Comma SHALL be ventana == 0011111010 or ventana == 1100000101 (K28.5, both disparities).
REQ-015 contBit (0..9) SHALL increment mod 10 on each enabled edge; a boundary is a cycle with contBit==0 and habilitar==1, judged on the pre-edge ventana.
REQ-016 In BUSCAR, any enabled cycle with a comma SHALL load contBit<=1 and cuentaComas<=1, and move to CONFIRMAR (to SINCRONIZADO directly if COMAS_SYNC==1).
REQ-017 In CONFIRMAR, a comma at a boundary SHALL increment cuentaComas; on reaching COMAS_SYNC, the FSM SHALL move to SINCRONIZADO with cuentaErr<=0.
REQ-018 In CONFIRMAR, a non-comma at a boundary SHALL return the FSM to BUSCAR; non-boundary commas SHALL be ignored.
REQ-019 In SINCRONIZADO, each boundary SHALL register palabra<=ventana and pulse palabraValida in the following cycle (latency 1 edge).
REQ-020 A boundary word SHALL be erroneous when its popcount is <4 or >6; otherwise it is good, commas included.
REQ-021 An erroneous word SHALL increment cuentaErr, and a good word SHALL clear it; on reaching ERRORES_PERDIDA, the FSM SHALL go to BUSCAR.
REQ-022 An erroneous word SHALL still be output with palabraValida=1, including the word that causes loss of sync.
REQ-023 rstContador SHALL be registered and equal 1 exactly when estado==BUSCAR; it falls in the first cycle estado leaves BUSCAR.
REQ-024 comaDetectada SHALL pulse one cycle after any enabled cycle whose ventana is a comma.
REQ-025 With habilitar=0, palabraValida and comaDetectada SHALL be 0, and ventana, contBit, counters and estado SHALL hold.
REQ-026 Counters SHALL saturate at their thresholds and never wrap.

Reset
REQ-027 rst=1 SHALL take priority over habilitar and all other inputs.
REQ-028 While rst=1: estado=BUSCAR, ventana=0, contBit=0, cuentaComas=0, cuentaErr=0.
REQ-029 While rst=1: palabra=0, palabraValida=0, sincronizado=0, comaDetectada=0, rstContador=1.
REQ-030 rst asserted mid-word or while SINCRONIZADO SHALL abort immediately; no palabraValida is emitted for the partial word.

Verification
REQ-031 Reset: rst=1 for 2 cycles from any state -> estado=0, rstContador=1, palabra=0, sincronizado=0, palabraValida=0.
REQ-032 Acquisition: habilitar=1, 3 junk bits then 3 commas 0011111010 MSB-first -> estado=1 after the first comma, rstContador=0, sincronizado=1 after the third boundary, no palabraValida before.
REQ-033 Data: after sync, send 1001101010 -> palabraValida=1 for one cycle, one edge after the boundary, with palabra=1001101010.
REQ-034 Loss: after sync, send 4 words 0000000000 -> sincronizado=0 and rstContador=1 after the 4th; 3 errors then 1100011010 -> sync kept, cuentaErr=0.
REQ-035 Confirm fail: comma, then 1001101010 -> estado returns to 0; comma, then habilitar=0 for 5 cycles mid-word, then resume -> boundary timing shifted by exactly 5 cycles.

Source files
------------

// File: rtl/controlador_alineamiento.sv
// Word alignment controller for a 10-bit serial line: hunts for K28.5 commas,
// confirms alignment on consecutive boundaries and emits aligned words while in sync.
module controlador_alineamiento #(
    parameter int COMAS_SYNC      = 3,
    parameter int ERRORES_PERDIDA = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entrada,
    input  logic       habilitar,
    output logic       rstContador,
    output logic [9:0] palabra,
    output logic       palabraValida,
    output logic       sincronizado,
    output logic       comaDetectada,
    output logic [1:0] estado
);

    localparam int CW = $clog2(COMAS_SYNC + 1);
    localparam int EW = $clog2(ERRORES_PERDIDA + 1);
    localparam logic [9:0] COMA_NEG = 10'b0011111010;
    localparam logic [9:0] COMA_POS = 10'b1100000101;

    typedef enum logic [1:0] {
        BUSCAR       = 2'd0,
        CONFIRMAR    = 2'd1,
        SINCRONIZADO = 2'd2
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [9:0]    ventana_q, ventana_d;
    logic [3:0]    cont_bit_q, cont_bit_d;
    logic [CW-1:0] cuenta_comas_q, cuenta_comas_d;
    logic [EW-1:0] cuenta_err_q, cuenta_err_d;
    logic [9:0]    palabra_q, palabra_d;
    logic          palabra_valida_q, palabra_valida_d;
    logic          coma_q, coma_d;
    logic          rst_contador_q, rst_contador_d;

    logic       es_coma;
    logic       frontera;
    logic [3:0] unos;
    logic       palabra_erronea;

    // Every decision is taken on the window as it stood before this edge's shift.
    assign es_coma         = (ventana_q == COMA_NEG) || (ventana_q == COMA_POS);
    assign frontera        = (cont_bit_q == 4'd0);
    assign unos            = 4'($countones(ventana_q));
    assign palabra_erronea = (unos < 4'd4) || (unos > 4'd6);

    always_comb begin
        estado_d         = estado_q;
        ventana_d        = ventana_q;
        cont_bit_d       = cont_bit_q;
        cuenta_comas_d   = cuenta_comas_q;
        cuenta_err_d     = cuenta_err_q;
        palabra_d        = palabra_q;
        palabra_valida_d = 1'b0;
        coma_d           = 1'b0;

        if (habilitar) begin
            ventana_d  = {ventana_q[8:0], entrada};
            cont_bit_d = (cont_bit_q == 4'd9) ? 4'd0 : cont_bit_q + 4'd1;
            coma_d     = es_coma;

            unique case (estado_q)
                BUSCAR: begin
                    // A comma anywhere fixes the phase: this edge counts as a boundary.
                    if (es_coma) begin
                        cont_bit_d     = 4'd1;
                        cuenta_comas_d = CW'(1);
                        if (COMAS_SYNC <= 1) begin
                            estado_d     = SINCRONIZADO;
                            cuenta_err_d = '0;
                        end else begin
                            estado_d = CONFIRMAR;
                        end
                    end
                end
                CONFIRMAR: begin
                    if (frontera) begin
                        if (!es_coma) begin
                            estado_d = BUSCAR;
                        end else if (cuenta_comas_q >= CW'(COMAS_SYNC - 1)) begin
                            cuenta_comas_d = CW'(COMAS_SYNC);
                            estado_d       = SINCRONIZADO;
                            cuenta_err_d   = '0;
                        end else begin
                            cuenta_comas_d = cuenta_comas_q + CW'(1);
                        end
                    end
                end
                SINCRONIZADO: begin
                    if (frontera) begin
                        palabra_d        = ventana_q;
                        palabra_valida_d = 1'b1;
                        if (!palabra_erronea) begin
                            cuenta_err_d = '0;
                        end else if (cuenta_err_q >= EW'(ERRORES_PERDIDA - 1)) begin
                            cuenta_err_d = EW'(ERRORES_PERDIDA);
                            estado_d     = BUSCAR;
                        end else begin
                            cuenta_err_d = cuenta_err_q + EW'(1);
                        end
                    end
                end
                default: estado_d = BUSCAR;
            endcase
        end

        rst_contador_d = (estado_d == BUSCAR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q         <= BUSCAR;
            ventana_q        <= '0;
            cont_bit_q       <= '0;
            cuenta_comas_q   <= '0;
            cuenta_err_q     <= '0;
            palabra_q        <= '0;
            palabra_valida_q <= 1'b0;
            coma_q           <= 1'b0;
            rst_contador_q   <= 1'b1;
        end else begin
            estado_q         <= estado_d;
            ventana_q        <= ventana_d;
            cont_bit_q       <= cont_bit_d;
            cuenta_comas_q   <= cuenta_comas_d;
            cuenta_err_q     <= cuenta_err_d;
            palabra_q        <= palabra_d;
            palabra_valida_q <= palabra_valida_d;
            coma_q           <= coma_d;
            rst_contador_q   <= rst_contador_d;
        end
    end

    assign estado        = estado_q;
    assign sincronizado  = (estado_q == SINCRONIZADO);
    assign palabra       = palabra_q;
    assign palabraValida = palabra_valida_q;
    assign comaDetectada = coma_q;
    assign rstContador   = rst_contador_q;

endmodule

// File: tb/tb_controlador_alineamiento.sv
// Bench for controlador_alineamiento: directed scenarios plus randomized streams
// compared against a phase-anchor reference model.
module tb_controlador_alineamiento;

    localparam int CS = 3;
    localparam int EP = 4;
    localparam logic [9:0] COMA     = 10'b0011111010;
    localparam logic [9:0] COMA_ALT = 10'b1100000101;
    localparam logic [9:0] DATO     = 10'b1001101010;
    localparam logic [9:0] BUENA    = 10'b1100011010;
    localparam logic [9:0] CERO     = 10'b0000000000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       entrada = 1'b0;
    logic       habilitar = 1'b0;
    logic       rstContador;
    logic [9:0] palabra;
    logic       palabraValida;
    logic       sincronizado;
    logic       comaDetectada;
    logic [1:0] estado;

    int tests_run = 0;
    int tests_failed = 0;

    controlador_alineamiento #(.COMAS_SYNC(CS), .ERRORES_PERDIDA(EP)) dut (
        .clk(clk), .rst(rst), .entrada(entrada), .habilitar(habilitar),
        .rstContador(rstContador), .palabra(palabra), .palabraValida(palabraValida),
        .sincronizado(sincronizado), .comaDetectada(comaDetectada), .estado(estado)
    );

    always #5 clk = ~clk;

    // Reference model: bit history queue, enabled-edge count and phase anchor.
    bit         m_q[$];
    int         m_n, m_anchor, m_st, m_commas, m_errs;
    logic [9:0] e_pal;
    logic       e_pv, e_coma;

    function automatic logic [9:0] m_window();
        logic [9:0] w = '0;
        foreach (m_q[i]) w = {w[8:0], m_q[i]};
        return w;
    endfunction

    task automatic model_update(input logic r, input logic en, input logic b);
        logic [9:0] w;
        bit comma, bnd;
        int pc;
        if (r) begin
            m_q.delete();
            repeat (10) m_q.push_back(1'b0);
            m_n = 0; m_anchor = 0; m_st = 0; m_commas = 0; m_errs = 0;
            e_pal = '0; e_pv = 1'b0; e_coma = 1'b0;
        end else if (!en) begin
            e_pv = 1'b0; e_coma = 1'b0;
        end else begin
            w      = m_window();
            comma  = (w == COMA) || (w == COMA_ALT);
            bnd    = ((m_n - m_anchor) % 10) == 0;
            e_coma = comma;
            e_pv   = 1'b0;
            if (m_st == 0) begin
                if (comma) begin
                    m_anchor = m_n;
                    m_commas = 1;
                    if (m_commas >= CS) begin m_st = 2; m_errs = 0; end
                    else m_st = 1;
                end
            end else if (m_st == 1) begin
                if (bnd) begin
                    if (comma) begin
                        m_commas++;
                        if (m_commas >= CS) begin m_st = 2; m_errs = 0; end
                    end else m_st = 0;
                end
            end else if (bnd) begin
                e_pal = w;
                e_pv  = 1'b1;
                pc    = $countones(w);
                if (pc < 4 || pc > 6) begin
                    m_errs++;
                    if (m_errs >= EP) m_st = 0;
                end else m_errs = 0;
            end
            m_q.push_back(b);
            void'(m_q.pop_front());
            m_n++;
        end
    endtask

    task automatic step(input logic r, input logic en, input logic b);
        @(negedge clk);
        rst = r; habilitar = en; entrada = b;
        @(posedge clk);
        model_update(r, en, b);
        #1;
    endtask

    // Sends 10 bits MSB-first, recording where/what palabraValida showed.
    task automatic send_word(input logic [9:0] w, output int pv_cnt, output int pv_at,
                             output logic [9:0] pv_word);
        pv_cnt = 0; pv_at = -1; pv_word = '0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, w[9-i]);
            if (palabraValida === 1'b1) begin
                pv_cnt++;
                if (pv_at < 0) begin pv_at = i; pv_word = palabra; end
            end
        end
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        tests_run++;
        if ({estado, rstContador, palabra, sincronizado, palabraValida, comaDetectada} !==
            {2'd0, 1'b1, 10'd0, 3'b000}) begin
            tests_failed++;
            $display("FAIL reset_state: got est=%0d rc=%b pal=%b sinc=%b pv=%b coma=%b want 0 1 0 0 0 0",
                     estado, rstContador, palabra, sincronizado, palabraValida, comaDetectada);
        end
    endtask

    task automatic test_acquisition();
        int c, a; logic [9:0] pw;
        int pv_total = 0;
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1); step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b1);
        send_word(COMA, c, a, pw); pv_total += c;
        tests_run++;
        if (estado !== 2'd0) begin
            tests_failed++; $display("FAIL acq_before_comma: estado=%0d want 0", estado);
        end
        step(1'b0, 1'b1, COMA[9]);
        tests_run++;
        if ({estado, rstContador, comaDetectada} !== {2'd1, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL acq_first_comma: est=%0d rc=%b coma=%b want 1 0 1", estado, rstContador, comaDetectada);
        end
        for (int i = 1; i < 10; i++) begin
            step(1'b0, 1'b1, COMA[9-i]);
            if (palabraValida === 1'b1) pv_total++;
        end
        send_word(COMA, c, a, pw); pv_total += c;
        tests_run++;
        if ({sincronizado, estado} !== {1'b0, 2'd1}) begin
            tests_failed++; $display("FAIL acq_pre_sync: sinc=%b est=%0d want 0 1", sincronizado, estado);
        end
        send_word(DATO, c, a, pw); pv_total += c;
        tests_run++;
        if ({sincronizado, estado, rstContador} !== {1'b1, 2'd2, 1'b0}) begin
            tests_failed++;
            $display("FAIL acq_sync: sinc=%b est=%0d rc=%b want 1 2 0", sincronizado, estado, rstContador);
        end
        tests_run++;
        if (pv_total !== 0) begin
            tests_failed++; $display("FAIL acq_no_pv: pv count=%0d want 0", pv_total);
        end
    endtask

    task automatic test_data();
        int c, a; logic [9:0] pw;
        send_word(BUENA, c, a, pw);
        tests_run++;
        if (c !== 1 || a !== 0 || pw !== DATO) begin
            tests_failed++;
            $display("FAIL data_word: pv_cnt=%0d at=%0d pal=%b want 1 0 %b", c, a, pw, DATO);
        end
    endtask

    task automatic test_loss();
        logic [9:0] seq [8];
        int c, a; logic [9:0] pw;
        int pv_total = 0;
        seq = '{CERO, CERO, CERO, BUENA, CERO, CERO, CERO, CERO};
        for (int k = 0; k < 8; k++) begin
            send_word(seq[k], c, a, pw);
            pv_total += c;
        end
        tests_run++;
        if ({sincronizado, estado, pv_total} !== {1'b1, 2'd2, 32'd8}) begin
            tests_failed++;
            $display("FAIL loss_kept: sinc=%b est=%0d pv=%0d want 1 2 8", sincronizado, estado, pv_total);
        end
        step(1'b0, 1'b1, 1'b1);
        tests_run++;
        if ({sincronizado, rstContador, estado, palabraValida, palabra} !==
            {1'b0, 1'b1, 2'd0, 1'b1, CERO}) begin
            tests_failed++;
            $display("FAIL loss_drop: sinc=%b rc=%b est=%0d pv=%b pal=%b want 0 1 0 1 0",
                     sincronizado, rstContador, estado, palabraValida, palabra);
        end
    endtask

    task automatic test_mid_reset();
        int c, a; logic [9:0] pw;
        int pv_total = 0;
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
        repeat (3) send_word(COMA, c, a, pw);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, DATO[9-i]);
        tests_run++;
        if (sincronizado !== 1'b1) begin
            tests_failed++; $display("FAIL midrst_sync: sinc=%b want 1", sincronizado);
        end
        step(1'b1, 1'b1, 1'b1); step(1'b1, 1'b1, 1'b0);
        tests_run++;
        if ({estado, rstContador, palabra, sincronizado, palabraValida} !== {2'd0, 1'b1, 10'd0, 2'b00}) begin
            tests_failed++;
            $display("FAIL midrst_state: est=%0d rc=%b pal=%b sinc=%b pv=%b want 0 1 0 0 0",
                     estado, rstContador, palabra, sincronizado, palabraValida);
        end
        for (int i = 5; i < 10; i++) begin
            step(1'b0, 1'b1, DATO[9-i]);
            if (palabraValida === 1'b1) pv_total++;
        end
        send_word(BUENA, c, a, pw); pv_total += c;
        tests_run++;
        if (pv_total !== 0) begin
            tests_failed++; $display("FAIL midrst_no_pv: pv count=%0d want 0", pv_total);
        end
    endtask

    // Comma, then a second word interrupted by a 5-cycle enable gap.
    task automatic test_confirm_fail();
        int c, a; logic [9:0] pw;
        logic [9:0] segunda [2];
        logic [1:0] want_est [2];
        segunda  = '{DATO, COMA};
        want_est = '{2'd0, 2'd1};
        step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
        send_word(COMA, c, a, pw);
        send_word(DATO, c, a, pw);
        step(1'b0, 1'b1, 1'b0);
        tests_run++;
        if (estado !== 2'd0) begin
            tests_failed++; $display("FAIL confirm_fail: estado=%0d want 0", estado);
        end
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
            send_word(COMA, c, a, pw);
            for (int i = 0; i < 5; i++) step(1'b0, 1'b1, segunda[k][9-i]);
            for (int g = 0; g < 5; g++) begin
                step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
                tests_run++;
                if ({estado, palabraValida, comaDetectada} !== {2'd1, 2'b00}) begin
                    tests_failed++;
                    $display("FAIL gap_hold: est=%0d pv=%b coma=%b want 1 0 0", estado, palabraValida, comaDetectada);
                end
            end
            for (int i = 5; i < 10; i++) step(1'b0, 1'b1, segunda[k][9-i]);
            tests_run++;
            if (estado !== 2'd1) begin
                tests_failed++; $display("FAIL gap_pre_boundary: estado=%0d want 1", estado);
            end
            step(1'b0, 1'b1, COMA[9]);
            tests_run++;
            if (estado !== want_est[k]) begin
                tests_failed++;
                $display("FAIL gap_boundary%0d: estado=%0d want %0d", k, estado, want_est[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [9:0] w;
        logic       r, en, b;
        int         kind, nbits;
        step(1'b1, 1'b1, 1'b0);
        for (int wi = 0; wi < 300; wi++) begin
            kind = $urandom_range(0, 9);
            if (kind < 4)      w = COMA;
            else if (kind < 5) w = COMA_ALT;
            else if (kind < 6) w = CERO;
            else               w = 10'($urandom);
            nbits = ($urandom_range(0, 9) == 0) ? 10 + $urandom_range(1, 3) : 10;
            for (int i = 0; i < nbits; i++) begin
                while ($urandom_range(0, 7) == 0) begin
                    step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
                    tests_run++;
                    if ({estado, rstContador, sincronizado, palabraValida, comaDetectada} !==
                        {m_st[1:0], m_st == 0, m_st == 2, e_pv, e_coma}) begin
                        tests_failed++;
                        $display("FAIL rand_idle: got est=%0d rc=%b sinc=%b pv=%b coma=%b want %0d %b %b %b %b",
                                 estado, rstContador, sincronizado, palabraValida, comaDetectada,
                                 m_st, m_st == 0, m_st == 2, e_pv, e_coma);
                    end
                end
                r  = ($urandom_range(0, 499) == 0);
                en = 1'b1;
                b  = (i < 10) ? w[9-i] : 1'($urandom_range(0, 1));
                step(r, en, b);
                tests_run++;
                if ({estado, rstContador, sincronizado, palabraValida, comaDetectada, palabra} !==
                    {m_st[1:0], m_st == 0, m_st == 2, e_pv, e_coma, e_pal}) begin
                    tests_failed++;
                    $display("FAIL rand_step: got est=%0d rc=%b sinc=%b pv=%b coma=%b pal=%b want %0d %b %b %b %b %b",
                             estado, rstContador, sincronizado, palabraValida, comaDetectada, palabra,
                             m_st, m_st == 0, m_st == 2, e_pv, e_coma, e_pal);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_acquisition();
        test_data();
        test_loss();
        test_reset();
        test_mid_reset();
        test_confirm_fail();
        test_random();
        test_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
